// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types, screen constants and ROM pattern for the sprite blitter
package sprite_pkg;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb444_t;

    localparam logic [10:0] H_ACTIVE        = 11'd640;
    localparam logic [10:0] V_ACTIVE        = 11'd480;
    localparam int          TRANSPARENT_IDX = 0;

    // Built-in texel image: index grows by 5 per texel, texel 0 opaque.
    function automatic logic [31:0] texel_pattern(input logic [31:0] addr, input logic [31:0] sel);
        return addr * 32'd5 + 32'd2 + sel;
    endfunction

endpackage

// File: rtl/sprite_blitter_if.sv
// rtl/sprite_blitter_if.sv - beam, sprite request and colour signals of the blitter
interface sprite_blitter_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       show;
    logic [3:0] bg_red;
    logic [3:0] bg_green;
    logic [3:0] bg_blue;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       hit;

    modport master (
        output DrawX, DrawY, blank, pos_x, pos_y, show, bg_red, bg_green, bg_blue,
        input  red, green, blue, hit
    );

    modport slave (
        input  DrawX, DrawY, blank, pos_x, pos_y, show, bg_red, bg_green, bg_blue,
        output red, green, blue, hit
    );
endinterface

// File: rtl/sprite_rom.sv
// rtl/sprite_rom.sv - sprite texel ROM, one-cycle synchronous read
module sprite_rom
    import sprite_pkg::*;
#(
    parameter int DEPTH    = 968,
    parameter int WIDTH    = 3,
    parameter int ADDR_W   = 10,
    parameter int INIT_SEL = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [WIDTH-1:0]  data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Addresses past the image read as transparent.
    always_comb begin
        data_d = '0;
        if (32'(addr_i) < 32'(DEPTH)) begin
            data_d = WIDTH'(texel_pattern(32'(addr_i), 32'(INIT_SEL)));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - scaled palette sprite composited over a background, 3-cycle pipeline
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int IMG_W = 44,
    parameter int IMG_H = 22,
    parameter int SCALE = 4,
    parameter int IDX_W = 3
) (
    input  logic            vga_clk,
    input  logic            reset_n,
    sprite_blitter_if.slave vga
);

    localparam int DEPTH  = IMG_W * IMG_H;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int COL_W  = $clog2(IMG_W + 1);
    localparam int ROW_W  = $clog2(IMG_H + 1);
    localparam int SUB_W  = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [10:0]      BOX_W    = 11'(IMG_W * SCALE);
    localparam logic [10:0]      BOX_H    = 11'(IMG_H * SCALE);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);

    logic [9:0]        sx_q, sy_q;
    logic              show_q;
    logic [COL_W-1:0]  col_q, col_d, cur_col;
    logic [SUB_W-1:0]  csub_q, csub_d, cur_csub;
    logic [ROW_W-1:0]  row_q, row_d, cur_row;
    logic [SUB_W-1:0]  rsub_q, rsub_d, cur_rsub;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              frame_origin, at_sx, in_x, in_y, in_box, vis;
    rgb444_t           bg_in, bg_q1, bg_q2, pix_q, pix_d, pal;
    logic              blank_q1, blank_q2, vis_q1, vis_q2, hit_q, hit_d;
    logic [IDX_W-1:0]  rom_idx;

    assign bg_in = '{red: vga.bg_red, green: vga.bg_green, blue: vga.bg_blue};

    // Box edges are 11 bits wide so a sprite near the right/bottom clips instead of wrapping.
    always_comb begin
        frame_origin = (vga.DrawX == 10'd0) && (vga.DrawY == 10'd0);
        at_sx  = (vga.DrawX == sx_q);
        in_x   = ({1'b0, vga.DrawX} >= {1'b0, sx_q}) && ({1'b0, vga.DrawX} < ({1'b0, sx_q} + BOX_W))
                 && ({1'b0, vga.DrawX} < H_ACTIVE);
        in_y   = ({1'b0, vga.DrawY} >= {1'b0, sy_q}) && ({1'b0, vga.DrawY} < ({1'b0, sy_q} + BOX_H))
                 && ({1'b0, vga.DrawY} < V_ACTIVE);
        in_box = in_x && in_y;
        vis    = in_box && show_q;
    end

    // Row state steps once per line on the left-edge pixel, so it is stable across the line.
    always_comb begin
        cur_row  = row_q;
        cur_rsub = rsub_q;
        if (at_sx && in_y) begin
            if (vga.DrawY == sy_q) begin
                cur_row  = '0;
                cur_rsub = '0;
            end else if (rsub_q == SUB_LAST) begin
                cur_row  = row_q + 1'b1;
                cur_rsub = '0;
            end else begin
                cur_rsub = rsub_q + 1'b1;
            end
        end
        row_d  = cur_row;
        rsub_d = cur_rsub;
    end

    // Column counters only move inside the box; a line wrap leaves them untouched.
    always_comb begin
        cur_col  = col_q;
        cur_csub = csub_q;
        if (at_sx) begin
            cur_col  = '0;
            cur_csub = '0;
        end
        col_d  = col_q;
        csub_d = csub_q;
        if (in_box) begin
            if (cur_csub == SUB_LAST) begin
                col_d  = cur_col + 1'b1;
                csub_d = '0;
            end else begin
                col_d  = cur_col;
                csub_d = cur_csub + 1'b1;
            end
        end
        addr_d = ADDR_W'(32'(cur_row) * 32'(IMG_W) + 32'(cur_col));
    end

    sprite_rom #(
        .DEPTH   (DEPTH),
        .WIDTH   (IDX_W),
        .ADDR_W  (ADDR_W),
        .INIT_SEL(0)
    ) u_rom (
        .clk    (vga_clk),
        .reset_n(reset_n),
        .addr_i (addr_q),
        .data_o (rom_idx)
    );

    always_comb begin
        pal = '{red: 4'h0, green: 4'h0, blue: 4'h0};
        case (32'(rom_idx))
            32'd1:   pal = '{red: 4'hF, green: 4'h0, blue: 4'h0};
            32'd2:   pal = '{red: 4'h0, green: 4'hF, blue: 4'h0};
            32'd3:   pal = '{red: 4'h0, green: 4'h0, blue: 4'hF};
            32'd4:   pal = '{red: 4'hF, green: 4'hF, blue: 4'h0};
            32'd5:   pal = '{red: 4'h0, green: 4'hF, blue: 4'hF};
            32'd6:   pal = '{red: 4'hF, green: 4'h0, blue: 4'hF};
            32'd7:   pal = '{red: 4'hF, green: 4'hF, blue: 4'hF};
            default: pal = '{red: 4'h8, green: 4'h8, blue: 4'h8};
        endcase
    end

    always_comb begin
        pix_d = '0;
        hit_d = 1'b0;
        if (blank_q2) begin
            if (vis_q2 && (rom_idx != IDX_W'(TRANSPARENT_IDX))) begin
                pix_d = pal;
                hit_d = 1'b1;
            end else begin
                pix_d = bg_q2;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            sx_q     <= '0;
            sy_q     <= '0;
            show_q   <= 1'b0;
            col_q    <= '0;
            csub_q   <= '0;
            row_q    <= '0;
            rsub_q   <= '0;
            addr_q   <= '0;
            bg_q1    <= '0;
            bg_q2    <= '0;
            blank_q1 <= 1'b0;
            blank_q2 <= 1'b0;
            vis_q1   <= 1'b0;
            vis_q2   <= 1'b0;
            pix_q    <= '0;
            hit_q    <= 1'b0;
        end else begin
            if (frame_origin) begin
                sx_q   <= vga.pos_x;
                sy_q   <= vga.pos_y;
                show_q <= vga.show;
            end
            col_q    <= col_d;
            csub_q   <= csub_d;
            row_q    <= row_d;
            rsub_q   <= rsub_d;
            addr_q   <= addr_d;
            bg_q1    <= bg_in;
            blank_q1 <= vga.blank;
            vis_q1   <= vis;
            bg_q2    <= bg_q1;
            blank_q2 <= blank_q1;
            vis_q2   <= vis_q1;
            pix_q    <= pix_d;
            hit_q    <= hit_d;
        end
    end

    assign vga.red   = pix_q.red;
    assign vga.green = pix_q.green;
    assign vga.blue  = pix_q.blue;
    assign vga.hit   = hit_q;

endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have parameter IMG_W, default 44, sprite width in texels.
REQ-002 SHALL have parameter IMG_H, default 22, sprite height in texels.
REQ-003 SHALL have parameter SCALE, default 4, integer screen pixels per texel in each axis, range 1..16.
REQ-004 SHALL have parameter IDX_W, default 3, palette index width; index 0 is transparent.
REQ-005 SHALL have port vga_clk, input, 1, pixel clock; the only clock.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port DrawX, input, 10, current beam column.
REQ-008 SHALL have port DrawY, input, 10, current beam row.
REQ-009 SHALL have port blank, input, 1, high = active video.
REQ-010 SHALL have port pos_x, input, 10, requested sprite top-left column.
REQ-011 SHALL have port pos_y, input, 10, requested sprite top-left row.
REQ-012 SHALL have port show, input, 1, requested sprite visibility.
REQ-013 SHALL have port bg_red/bg_green/bg_blue, input, 4 each, background colour for the current DrawX/DrawY.
REQ-014 SHALL have port red/green/blue, output, 4 each, composited colour.
REQ-015 SHALL have port hit, output, 1, high when the output pixel is opaque sprite.

Function
REQ-016 SHALL latch pos_x, pos_y, show into shadow registers only on the cycle with DrawX==0 and DrawY==0; all drawing uses the shadow values (no mid-frame tearing).
REQ-017 SHALL define the sprite box as DrawX in [sx, sx+IMG_W*SCALE) and DrawY in [sy, sy+IMG_H*SCALE), computed 11 bits wide; box parts beyond 639/479 are clipped, no wrap-around.
REQ-018 SHALL derive texel coordinates with counters, no divider: column counter resets to 0 and sub-counter to 0 when DrawX==sx; sub-counter counts 0..SCALE-1, column increments on sub-counter wrap.
REQ-019 SHALL derive texel row likewise, advancing the row sub-counter once per scanline on the DrawX==sx cycle of rows after sy, resetting both at DrawY==sy.
REQ-020 SHALL form ROM address = row*IMG_W + col, registered (stage 1).
REQ-021 SHALL read the ROM with 1-cycle synchronous latency (stage 2) and palette-map combinationally.
REQ-022 SHALL register outputs (stage 3); total latency from DrawX/DrawY/bg_* to red/green/blue/hit is exactly 3 vga_clk cycles.
REQ-023 SHALL delay bg_*, blank and in-box flag through matching 3-stage pipelines.
REQ-024 SHALL output palette colour and hit=1 when delayed blank=1, in-box=1, shadow show=1 and index!=0.
REQ-025 SHALL output delayed bg colour and hit=0 when blank=1 and the pixel is transparent, outside the box, or show=0.
REQ-026 SHALL output 0/0/0 and hit=0 when delayed blank=0.
REQ-027 SHALL keep counters stable (no advance) outside the box so that a DrawX discontinuity (line wrap) cannot corrupt the next row.

Reset
REQ-028 SHALL on reset_n low asynchronously clear red/green/blue, hit, all pipeline registers, counters, shadow show (0) and shadow position (0,0).
REQ-029 SHALL, after reset deassertion mid-frame, output only background until the next DrawX==0,DrawY==0 latch.

Structure
REQ-030 SHALL place typedef rgb444_t, screen constants H_ACTIVE=640, V_ACTIVE=480, and the transparent index constant in package sprite_pkg.
REQ-031 SHALL instantiate one sub-module sprite_rom (parametrised depth IMG_W*IMG_H, width IDX_W, synchronous read, init file parameter); palette is a combinational case inside the block.

Verification
REQ-032 Reset held low 5 cycles mid-line -> outputs 0, hit 0 throughout; release -> background only until frame origin.
REQ-033 pos=(100,50), show=1, SCALE=4, texel(0,0) opaque index 2 -> DrawX=100,DrawY=50 produces palette[2], hit=1, exactly 3 cycles later; DrawX=99 produces bg.
REQ-034 Same setup -> DrawX=103 maps col 0, DrawX=104 col 1, DrawY=54 row 1; last box pixel (275,137), DrawX=276 -> bg.
REQ-035 pos_x changed to 300 mid-frame -> current frame still drawn at 100; next frame at 300.
REQ-036 pos=(600,460) -> columns 600..639 and rows 460..479 drawn, no pixels at column 0 or row 0.
REQ-037 Transparent texel (index 0) inside box, and blank=0 inside box -> bg colour with hit=0, and 0/0/0 respectively.
